// File: rtl/alu_pipe_mul.sv
// Registered LAC ALU with valid/ready handshake and an iterative shift-add multiply on op 3'b111.
// Optional ALU_SAT_EN: add/sub results saturate on signed overflow instead of wrapping.
module alu_pipe_mul #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       S,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             Cout,
    output logic             V,
    output logic             Z,
    output logic             N
);

    typedef enum logic {IDLE, MUL} state_t;

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt_p0;
    logic [2*WIDTH-1:0]     mpd_p0, acc_p0, prod;
    logic [WIDTH-1:0]       mpr_p0;
    logic                   accept, mul_start, mul_last, load;
    logic [WIDTH-1:0]       b_op, alu_d, res_d;
    logic [WIDTH:0]         sum;
    logic                   alu_c, alu_v, res_c, res_v, arith_v;

`ifdef ALU_SAT_EN
    function automatic logic [WIDTH-1:0] sat_addsub(input logic [WIDTH-1:0] r,
                                                    input logic ovf, input logic a_neg);
        logic signed [WIDTH-1:0] smax, smin;
        smax = {1'b0, {(WIDTH-1){1'b1}}};
        smin = {1'b1, {(WIDTH-1){1'b0}}};
        if (!ovf)
            return r;
        return a_neg ? smin : smax;
    endfunction
`endif

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (S == 3'b111);
    assign mul_last  = (state == MUL) && (cnt_p0 == CNT_W'(WIDTH - 1));
    assign load      = (accept && (S != 3'b111)) || mul_last;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (mul_start) state_nx = MUL;
            MUL:     if (mul_last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt_p0 <= '0;
        end else begin
            state <= state_nx;
            if (mul_start)
                cnt_p0 <= '0;
            else if (state == MUL)
                cnt_p0 <= cnt_p0 + 1'b1;
        end
    end

    // Single-cycle ops: sub reuses the adder with b inverted, Cin supplies the +1.
    always_comb begin
        b_op    = S[0] ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, Cin};
        arith_v = (a[WIDTH-1] ^ b_op[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
        alu_d   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (S)
            3'b000: alu_d = a ^ b;
            3'b001: alu_d = ~(a ^ b);
            3'b010, 3'b011: begin
`ifdef ALU_SAT_EN
                alu_d = sat_addsub(sum[WIDTH-1:0], arith_v, a[WIDTH-1]);
`else
                alu_d = sum[WIDTH-1:0];
`endif
                alu_c = sum[WIDTH];
                alu_v = arith_v;
            end
            3'b100: alu_d = a | b;
            3'b101: alu_d = ~(a | b);
            3'b110: alu_d = a & b;
            default: alu_d = '0;
        endcase
    end

    // Multiply step: prod is the accumulator after this edge's conditional add.
    assign prod  = acc_p0 + (mpr_p0[0] ? mpd_p0 : '0);
    assign res_d = mul_last ? prod[WIDTH-1:0] : alu_d;
    assign res_c = mul_last ? |prod[2*WIDTH-1:WIDTH] : alu_c;
    assign res_v = mul_last ? 1'b0 : alu_v;

    always_ff @(posedge clk) begin
        if (mul_start) begin
            mpd_p0 <= {{WIDTH{1'b0}}, a};
            mpr_p0 <= b;
            acc_p0 <= '0;
        end else if (state == MUL) begin
            acc_p0 <= prod;
            mpd_p0 <= mpd_p0 << 1;
            mpr_p0 <= mpr_p0 >> 1;
        end
    end

    // Output register: held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            d         <= '0;
            Cout      <= 1'b0;
            V         <= 1'b0;
            Z         <= 1'b0;
            N         <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            d         <= res_d;
            Cout      <= res_c;
            V         <= res_v;
            Z         <= (res_d == '0);
            N         <= res_d[WIDTH-1];
        end else if (mul_start || out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
